// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
// Execute-stage ALU for the GPU core. It accepts one operation per in_valid /
// in_ready handshake and returns a registered result, NZP flags and a
// divide-by-zero flag on an out_valid / out_ready handshake.
// ADD/SUB/MUL/MULH/CMP (and reserved op 7, which behaves as ADD) complete in
// one cycle. DIV/REM with a non-zero divisor run an iterative restoring divider
// for DATA_W cycles on operand magnitudes, and the signs are fixed up when it
// finishes.
//
// Ports
//   clk          in   1       rising-edge clock
//   reset_n      in   1       asynchronous active-low reset
//   in_valid     in   1       operation presented
//   in_ready     out  1       operation can be accepted this cycle
//   op           in   OP_W    0 ADD, 1 SUB, 2 MUL, 3 MULH, 4 DIV, 5 REM,
//                             6 CMP, 7 reserved (= ADD)
//   signed_mode  in   1       1 = two's-complement operands, 0 = unsigned
//   rs, rt       in   DATA_W  source operands
//   out_valid    out  1       result/flags valid
//   out_ready    in   1       consumer takes the result
//   result       out  DATA_W  arithmetic result, or {0..,N,Z,P} for CMP
//   nzp          out  3       {N,Z,P} of the result (CMP: rs compared with rt)
//   div_by_zero  out  1       DIV/REM issued with rt == 0
//   busy         out  1       divider iterating
// -----------------------------------------------------------------------------
module alu_multicycle #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        nzp,
  output logic              div_by_zero,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MULH = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_REM  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(6);

  typedef enum logic {
    S_IDLE,
    S_DIV_RUN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_result;
  logic [2:0]          r_nzp;
  logic                r_dbz;

  // Divider state: r_quot starts as the dividend magnitude and shifts out its
  // MSB each iteration while quotient bits shift in at the bottom.
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quot;
  logic [DATA_W-1:0]   r_divisor;
  logic [CNT_W-1:0]    r_count;
  logic                r_is_rem;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_signed;

  logic                w_accept;
  logic                w_is_div;
  logic                w_div_start;
  logic                w_div_done;

  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic [2*DATA_W-1:0] w_ext_rs;
  logic [2*DATA_W-1:0] w_ext_rt;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_lt;
  logic                w_eq;
  logic [DATA_W-1:0]   w_sc_result;
  logic [2:0]          w_sc_nzp;
  logic                w_sc_dbz;

  logic [DATA_W-1:0]   w_rs_mag;
  logic [DATA_W-1:0]   w_rt_mag;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_rem_diff;
  logic                w_ge;
  logic [DATA_W-1:0]   w_rem_next;
  logic [DATA_W-1:0]   w_quot_next;
  logic [DATA_W-1:0]   w_q_fix;
  logic [DATA_W-1:0]   w_r_fix;
  logic [DATA_W-1:0]   w_div_val;

  function automatic logic [2:0] f_nzp(input logic [DATA_W-1:0] v, input logic s);
    logic n;
    logic z;
    n = s && v[DATA_W-1];
    z = (v == '0);
    return {n, z, !n && !z};
  endfunction

  assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_is_div    = (op == OP_DIV) || (op == OP_REM);
  assign w_div_start = w_accept && w_is_div && (rt != '0);

  // Single-cycle datapath
  assign w_sum    = rs + rt;
  assign w_diff   = rs - rt;
  assign w_ext_rs = signed_mode ? {{DATA_W{rs[DATA_W-1]}}, rs} : {{DATA_W{1'b0}}, rs};
  assign w_ext_rt = signed_mode ? {{DATA_W{rt[DATA_W-1]}}, rt} : {{DATA_W{1'b0}}, rt};
  // Truncating the 2W x 2W product of the extended operands to 2W bits gives
  // the exact signed or unsigned double-width product.
  assign w_prod   = w_ext_rs * w_ext_rt;
  assign w_lt     = signed_mode ? ($signed(rs) < $signed(rt)) : (rs < rt);
  assign w_eq     = (rs == rt);

  always_comb begin
    w_sc_result = w_sum;
    w_sc_dbz    = 1'b0;
    case (op)
      OP_SUB:  w_sc_result = w_diff;
      OP_MUL:  w_sc_result = w_prod[DATA_W-1:0];
      OP_MULH: w_sc_result = w_prod[2*DATA_W-1:DATA_W];
      OP_DIV: begin
        w_sc_result = '1;
        w_sc_dbz    = 1'b1;
      end
      OP_REM: begin
        w_sc_result = rs;
        w_sc_dbz    = 1'b1;
      end
      OP_CMP: begin
        w_sc_result      = '0;
        w_sc_result[2:0] = {w_lt, w_eq, !w_lt && !w_eq};
      end
      default: w_sc_result = w_sum;
    endcase
    w_sc_nzp = (op == OP_CMP) ? {w_lt, w_eq, !w_lt && !w_eq}
                              : f_nzp(w_sc_result, signed_mode);
  end

  // Divider datapath. MIN negates to itself, which is the correct unsigned
  // magnitude 2^(W-1), so MIN / -1 falls out as quotient MIN, remainder 0.
  assign w_rs_mag    = (signed_mode && rs[DATA_W-1]) ? -rs : rs;
  assign w_rt_mag    = (signed_mode && rt[DATA_W-1]) ? -rt : rt;
  assign w_rem_sh    = {r_rem, r_quot[DATA_W-1]};
  assign w_rem_diff  = w_rem_sh - {1'b0, r_divisor};
  // Partial remainder stays below 2*divisor, so the borrow bit is a valid compare.
  assign w_ge        = !w_rem_diff[DATA_W];
  assign w_rem_next  = w_ge ? w_rem_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
  assign w_quot_next = {r_quot[DATA_W-2:0], w_ge};
  assign w_q_fix     = r_neg_q ? -w_quot_next : w_quot_next;
  assign w_r_fix     = r_neg_r ? -w_rem_next  : w_rem_next;
  assign w_div_val   = r_is_rem ? w_r_fix : w_q_fix;

  always_comb begin
    w_state_nxt = r_state;
    w_div_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_div_start) w_state_nxt = S_DIV_RUN;
      end
      S_DIV_RUN: begin
        if (r_count == LAST_ITER) begin
          w_state_nxt = S_IDLE;
          w_div_done  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_nzp       <= '0;
      r_dbz       <= 1'b0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      r_is_rem    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_signed    <= 1'b0;
    end else begin
      if (w_div_start) begin
        r_rem     <= '0;
        r_quot    <= w_rs_mag;
        r_divisor <= w_rt_mag;
        r_count   <= '0;
        r_is_rem  <= (op == OP_REM);
        r_neg_q   <= signed_mode && (rs[DATA_W-1] ^ rt[DATA_W-1]);
        r_neg_r   <= signed_mode && rs[DATA_W-1];
        r_signed  <= signed_mode;
      end else if (r_state == S_DIV_RUN) begin
        r_rem   <= w_rem_next;
        r_quot  <= w_quot_next;
        r_count <= r_count + 1'b1;
      end

      if (w_accept && !w_div_start) begin
        r_result    <= w_sc_result;
        r_nzp       <= w_sc_nzp;
        r_dbz       <= w_sc_dbz;
        r_out_valid <= 1'b1;
      end else if (w_div_done) begin
        r_result    <= w_div_val;
        r_nzp       <= f_nzp(w_div_val, r_signed);
        r_dbz       <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign nzp         = r_nzp;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state == S_DIV_RUN);

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
// Directed scoreboard bench for alu_multicycle (DATA_W=8). The stimulus
// process pushes the hand-computed expected response when an operation is
// accepted; an independent monitor pops and compares every result transfer,
// including the accept-to-valid latency.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] MULH = 3'd3;
  localparam logic [2:0] DIV  = 3'd4;
  localparam logic [2:0] REM  = 3'd5;
  localparam logic [2:0] CMP  = 3'd6;
  localparam logic [2:0] RSV  = 3'd7;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = '0;
  logic       signed_mode = 1'b0;
  logic [7:0] rs = '0;
  logic [7:0] rt = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [2:0] nzp;
  logic       div_by_zero;
  logic       busy;

  alu_multicycle #(.DATA_W(8), .OP_W(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .signed_mode (signed_mode),
    .rs          (rs),
    .rt          (rt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .nzp         (nzp),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic [2:0] nzp;
    logic       dbz;
    int         lat;
    int         acc;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: pops one expectation per out_valid && out_ready transfer.
  bit   mon_prev_v = 1'b0;
  bit   mon_prev_x = 1'b0;
  int   mon_pres = 0;
  exp_t mon_e;
  string mon_nm;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_prev_v = 1'b0;
        mon_prev_x = 1'b0;
      end else begin
        if (out_valid && (!mon_prev_v || mon_prev_x)) mon_pres = cyc;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'(out_valid), 32'd0);
          end else begin
            mon_e  = sb.pop_front();
            mon_nm = sb_name.pop_front();
            chk({mon_nm, "_result"}, 32'(result), 32'(mon_e.res));
            chk({mon_nm, "_nzp"}, 32'(nzp), 32'(mon_e.nzp));
            chk({mon_nm, "_dbz"}, 32'(div_by_zero), 32'(mon_e.dbz));
            chk({mon_nm, "_latency"}, 32'(mon_pres - mon_e.acc + 1), 32'(mon_e.lat));
          end
        end
        mon_prev_v = out_valid;
        mon_prev_x = out_valid && out_ready;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic sm, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic [2:0] en,
                       input logic ed, input int lat, input string nm, output int waited);
    exp_t e;
    bit   ok;
    in_valid    = 1'b1;
    op          = o;
    signed_mode = sm;
    rs          = a;
    rt          = b;
    ok          = 1'b0;
    waited      = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = er;
        e.nzp = en;
        e.dbz = ed;
        e.lat = lat;
        e.acc = cyc + 1;
        sb.push_back(e);
        sb_name.push_back(nm);
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_accept: in_ready stayed 0 for 50 cycles, required 1", nm);
    end
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the ALU must use the captured values.
    in_valid    = 1'b0;
    rs          = 8'h5A;
    rt          = 8'hC3;
    op          = SUB;
    signed_mode = ~sm;
  endtask

  task automatic go(input logic [2:0] o, input logic sm, input logic [7:0] a,
                    input logic [7:0] b, input logic [7:0] er, input logic [2:0] en,
                    input logic ed, input int lat, input string nm);
    int w;
    issue(o, sm, a, b, er, en, ed, lat, nm, w);
  endtask

  task automatic wait_drain(input string nm, output int busy_n);
    bit ok;
    busy_n = 0;
    ok     = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (busy) busy_n++;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: %0d results outstanding after 100 cycles, required 0", nm, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn;
    int w;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_nzp", 32'(nzp), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-cycle ops
    go(ADD, 1'b0, 8'hC8, 8'h64, 8'h2C, 3'b001, 1'b0, 1, "add_u");
    go(SUB, 1'b0, 8'h05, 8'h05, 8'h00, 3'b010, 1'b0, 1, "sub_zero");
    go(ADD, 1'b1, 8'h7F, 8'h01, 8'h80, 3'b100, 1'b0, 1, "add_s_wrap");
    go(SUB, 1'b1, 8'h03, 8'h05, 8'hFE, 3'b100, 1'b0, 1, "sub_s_neg");
    go(RSV, 1'b0, 8'h03, 8'h04, 8'h07, 3'b001, 1'b0, 1, "op7_add");

    // Signed division with busy-length check
    go(DIV, 1'b1, 8'hF9, 8'h02, 8'hFD, 3'b100, 1'b0, 9, "div_s_m7_2");
    wait_drain("div_s_m7_2", bn);
    chk("div_busy_cycles", 32'(bn), 32'd8);
    go(REM, 1'b1, 8'hF9, 8'h02, 8'hFF, 3'b100, 1'b0, 9, "rem_s_m7_2");
    go(DIV, 1'b1, 8'h07, 8'hFE, 8'hFD, 3'b100, 1'b0, 9, "div_s_7_m2");
    go(REM, 1'b1, 8'h07, 8'hFE, 8'h01, 3'b001, 1'b0, 9, "rem_s_7_m2");
    go(DIV, 1'b0, 8'hC8, 8'h07, 8'h1C, 3'b001, 1'b0, 9, "div_u_200_7");
    go(REM, 1'b0, 8'hC8, 8'h07, 8'h04, 3'b001, 1'b0, 9, "rem_u_200_7");

    // Divide by zero and signed overflow
    go(DIV, 1'b0, 8'h05, 8'h00, 8'hFF, 3'b001, 1'b1, 1, "div_by0_u");
    go(REM, 1'b0, 8'h05, 8'h00, 8'h05, 3'b001, 1'b1, 1, "rem_by0_u");
    go(DIV, 1'b1, 8'h05, 8'h00, 8'hFF, 3'b100, 1'b1, 1, "div_by0_s");
    go(DIV, 1'b1, 8'h80, 8'hFF, 8'h80, 3'b100, 1'b0, 9, "div_s_ovf");
    go(REM, 1'b1, 8'h80, 8'hFF, 8'h00, 3'b010, 1'b0, 9, "rem_s_ovf");

    // Multiply and compare
    go(MULH, 1'b1, 8'h80, 8'h80, 8'h40, 3'b001, 1'b0, 1, "mulh_s");
    go(MULH, 1'b0, 8'hFF, 8'hFF, 8'hFE, 3'b001, 1'b0, 1, "mulh_u");
    go(MUL,  1'b0, 8'hFF, 8'hFF, 8'h01, 3'b001, 1'b0, 1, "mul_u");
    go(MULH, 1'b1, 8'hFF, 8'h02, 8'hFF, 3'b100, 1'b0, 1, "mulh_s_neg");
    go(CMP,  1'b1, 8'hFF, 8'h01, 8'h04, 3'b100, 1'b0, 1, "cmp_s");
    go(CMP,  1'b0, 8'hFF, 8'h01, 8'h01, 3'b001, 1'b0, 1, "cmp_u");
    go(CMP,  1'b1, 8'h05, 8'h05, 8'h02, 3'b010, 1'b0, 1, "cmp_eq");

    // Backpressure: result held stable, no accept while stalled
    wait_drain("pre_bp", bn);
    out_ready = 1'b0;
    go(ADD, 1'b0, 8'h0A, 8'h14, 8'h1E, 3'b001, 1'b0, 1, "bp_add");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result_stable", 32'(result), 32'h1E);
      chk("bp_nzp_stable", 32'(nzp), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(SUB, 1'b0, 8'h09, 8'h04, 8'h05, 3'b001, 1'b0, 1, "drain_sub", w);
    chk("drain_accept_same_cycle", 32'(w), 32'd0);

    // Reset in the middle of a division
    wait_drain("pre_rst", bn);
    go(DIV, 1'b0, 8'hC8, 8'h07, 8'h1C, 3'b001, 1'b0, 9, "div_aborted");
    repeat (3) @(posedge clk);
    #3;
    chk("mid_div_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    sb.delete();
    sb_name.delete();
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_result", 32'(result), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    go(ADD, 1'b0, 8'h01, 8'h01, 8'h02, 3'b001, 1'b0, 1, "post_rst_add");
    wait_drain("final", bn);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
